md_issue_ctrl: RTL and testbench

MD_ISSUE_CTRL -- requirements
Module: md_issue_ctrl

---
 rtl/md_issue_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_md_issue_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/md_issue_ctrl.sv
// -----------------------------------------------------------------------------
// md_issue_ctrl
//
// Issue controller for a multiply/divide unit sitting beside the E stage.
// Decodes the E-stage md_op, starts the mult/div unit, drives HI/LO write
// and readback controls, and holds the pipeline at E while an arithmetic
// op is in flight (5 busy cycles for MULT/MADD, 10 for DIV).
//
// Optional feature: define MD_MADD_EN to enable MADD/MADDU (codes 9/10).
// Without it those codes decode as NONE (no issue, no stall).
//
// Ports
//   clk           in   clock, all state updates on the rising edge
//   reset         in   synchronous, active-high reset
//   e_valid       in   E-stage instruction is valid
//   md_op   [3:0] in   0 NONE 1 MULT 2 MULTU 3 DIV 4 DIVU 5 MTHI 6 MTLO
//                      7 MFHI 8 MFLO 9 MADD 10 MADDU, 11-15 NONE
//   rs_val [31:0] in   forwarded rs operand
//   rt_val [31:0] in   forwarded rt operand
//   flush         in   cancels the E-stage instruction this cycle
//   md_cal  [1:0] out  unit start code: 00 none 01 MULT 10 DIV 11 MADD
//   other_reg_wr  out  HI/LO write code: 00 none 01 HI 10 LO
//   op_a, op_b    out  operands to the unit (0 when nothing is issued)
//   op_signed     out  signed-operation flag
//   rd_hilo_en    out  HI/LO readback enable
//   rd_hilo_sel   out  readback select: 0 HI, 1 LO
//   stall         out  freezes the pipeline at E
//   busy          out  an arithmetic op is in flight
// -----------------------------------------------------------------------------
module md_issue_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        e_valid,
    input  logic [3:0]  md_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        flush,
    output logic [1:0]  md_cal,
    output logic [1:0]  other_reg_wr,
    output logic [31:0] op_a,
    output logic [31:0] op_b,
    output logic        op_signed,
    output logic        rd_hilo_en,
    output logic        rd_hilo_sel,
    output logic        stall,
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } state_e;

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MTHI  = 4'd5,
        OP_MTLO  = 4'd6,
        OP_MFHI  = 4'd7,
        OP_MFLO  = 4'd8,
        OP_MADD  = 4'd9,
        OP_MADDU = 4'd10
    } md_op_e;

    localparam logic [1:0] CAL_NONE = 2'b00;
    localparam logic [1:0] CAL_MULT = 2'b01;
    localparam logic [1:0] CAL_DIV  = 2'b10;
    localparam logic [1:0] CAL_MADD = 2'b11;

    localparam logic [1:0] WR_NONE = 2'b00;
    localparam logic [1:0] WR_HI   = 2'b01;
    localparam logic [1:0] WR_LO   = 2'b10;

    // Counter load values equal the number of busy cycles after issue.
    localparam logic [3:0] CNT_MUL = 4'd5;
    localparam logic [3:0] CNT_DIV = 4'd10;

    state_e     state_q, state_d;
    logic [3:0] cnt_q,   cnt_d;

    // ---------------------------------------------------------------------
    // Opcode decode
    // ---------------------------------------------------------------------
    logic is_mul, is_div, is_madd, is_mthi, is_mtlo, is_mfhi, is_mflo;
    logic is_arith, op_valid, dec_signed;

    // NOTE: every signal assigned in an always_comb gets a default first so
    // no path leaves it unassigned; otherwise a latch is inferred.
    always_comb begin
        is_mul     = 1'b0;
        is_div     = 1'b0;
        is_madd    = 1'b0;
        is_mthi    = 1'b0;
        is_mtlo    = 1'b0;
        is_mfhi    = 1'b0;
        is_mflo    = 1'b0;
        dec_signed = 1'b0;

        case (md_op)
            OP_MULT:  begin is_mul = 1'b1; dec_signed = 1'b1; end
            OP_MULTU: is_mul = 1'b1;
            OP_DIV:   begin is_div = 1'b1; dec_signed = 1'b1; end
            OP_DIVU:  is_div = 1'b1;
            OP_MTHI:  is_mthi = 1'b1;
            OP_MTLO:  is_mtlo = 1'b1;
            OP_MFHI:  is_mfhi = 1'b1;
            OP_MFLO:  is_mflo = 1'b1;
`ifdef MD_MADD_EN
            OP_MADD:  begin is_madd = 1'b1; dec_signed = 1'b1; end
            OP_MADDU: is_madd = 1'b1;
`endif
            // NONE, 11-15 and (without MADD support) 9/10 decode as NONE.
            default:  ;
        endcase

        is_arith = is_mul | is_div | is_madd;
        op_valid = is_arith | is_mthi | is_mtlo | is_mfhi | is_mflo;
    end

    // ---------------------------------------------------------------------
    // Handshake, outputs and next state
    // ---------------------------------------------------------------------
    logic accept;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        md_cal       = CAL_NONE;
        other_reg_wr = WR_NONE;
        op_a         = '0;
        op_b         = '0;
        op_signed    = 1'b0;
        rd_hilo_en   = 1'b0;
        rd_hilo_sel  = 1'b0;

        busy  = (state_q != ST_IDLE);
        // Any real md op arriving while the unit is busy must wait at E,
        // including HI/LO moves, since they would race the in-flight result.
        stall = busy & e_valid & op_valid;

        // Reset wins over any accept; flush cancels the E-stage op, so both
        // suppress every pulse this cycle.
        accept = ~reset & e_valid & ~flush & ~stall & op_valid;

        if (accept) begin
            if (is_arith) begin
                op_a      = rs_val;
                op_b      = rt_val;
                op_signed = dec_signed;
                if (is_mul)
                    md_cal = CAL_MULT;
                else if (is_div)
                    md_cal = CAL_DIV;
                else
                    md_cal = CAL_MADD;
            end
            if (is_mthi | is_mtlo) begin
                op_a         = rs_val;
                other_reg_wr = is_mthi ? WR_HI : WR_LO;
            end
            if (is_mfhi | is_mflo) begin
                rd_hilo_en  = 1'b1;
                rd_hilo_sel = is_mflo;
            end
        end

        case (state_q)
            ST_IDLE: begin
                // An accept is only possible with busy=0, so arithmetic
                // issue always starts from here (including the cycle a
                // previous op has just returned to IDLE).
                if (accept && (is_mul || is_madd)) begin
                    state_d = ST_MUL;
                    cnt_d   = CNT_MUL;
                end else if (accept && is_div) begin
                    state_d = ST_DIV;
                    cnt_d   = CNT_DIV;
                end
            end
            ST_MUL, ST_DIV: begin
                // Flush does not cancel an op in flight: keep counting.
                if (cnt_q <= 4'd1) begin
                    state_d = ST_IDLE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------------
    // NOTE: sequential state is written with non-blocking assignments so
    // every flop samples the pre-edge value of the others.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_md_issue_ctrl.sv
// -----------------------------------------------------------------------------
// tb_md_issue_ctrl
//
// Self-checking bench for md_issue_ctrl. A cycle-level reference model tracks
// only "remaining busy cycles" and derives every expected output from the
// opcode rules; directed scenarios are followed by a randomized run.
// Define MD_MADD_EN for both bench and RTL to exercise MADD/MADDU.
// -----------------------------------------------------------------------------
module tb_md_issue_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        e_valid;
    logic [3:0]  md_op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        flush;
    logic [1:0]  md_cal;
    logic [1:0]  other_reg_wr;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        op_signed;
    logic        rd_hilo_en;
    logic        rd_hilo_sel;
    logic        stall;
    logic        busy;

    md_issue_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .e_valid      (e_valid),
        .md_op        (md_op),
        .rs_val       (rs_val),
        .rt_val       (rt_val),
        .flush        (flush),
        .md_cal       (md_cal),
        .other_reg_wr (other_reg_wr),
        .op_a         (op_a),
        .op_b         (op_b),
        .op_signed    (op_signed),
        .rd_hilo_en   (rd_hilo_en),
        .rd_hilo_sel  (rd_hilo_sel),
        .stall        (stall),
        .busy         (busy)
    );

    always #5 clk = ~clk;

`ifdef MD_MADD_EN
    localparam bit MADD_EN = 1'b1;
`else
    localparam bit MADD_EN = 1'b0;
`endif

    int n_checks = 0;
    int n_fails  = 0;

    // Reference model state: number of busy cycles still to come.
    int rem = 0;

    // Observation counters for directed scenarios.
    int busy_seen;
    int stall_seen;
    int cal_pulses;
    int hilo_pulses;
    int wr_pulses;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, compare every output against the model,
    // then advance the model across the coming rising edge.
    task automatic cyc(input string tag, input logic rst, input logic ev,
                       input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic fl);
        bit          valid_op, is_arith, acc, exp_busy, exp_stall;
        logic [1:0]  e_cal, e_wr;
        logic [31:0] e_a, e_b;
        logic        e_sgn, e_en, e_sel;
        int          o;

        @(negedge clk);
        reset   = rst;
        e_valid = ev;
        md_op   = op;
        rs_val  = a;
        rt_val  = b;
        flush   = fl;
        #1;

        o        = int'(op);
        is_arith = (o >= 1 && o <= 4) || (MADD_EN && (o == 9 || o == 10));
        valid_op = is_arith || (o >= 5 && o <= 8);

        exp_busy  = (rem > 0);
        exp_stall = exp_busy && ev && valid_op;
        acc       = !rst && ev && !fl && !exp_stall && valid_op;

        e_cal = 2'b00;
        if (acc && (o == 1 || o == 2)) e_cal = 2'b01;
        if (acc && (o == 3 || o == 4)) e_cal = 2'b10;
        if (acc && is_arith && (o == 9 || o == 10)) e_cal = 2'b11;
        e_wr  = !acc ? 2'b00 : (o == 5) ? 2'b01 : (o == 6) ? 2'b10 : 2'b00;
        e_a   = (acc && (is_arith || o == 5 || o == 6)) ? a : 32'h0;
        e_b   = (acc && is_arith) ? b : 32'h0;
        e_sgn = acc && is_arith && (o == 1 || o == 3 || o == 9);
        e_en  = acc && (o == 7 || o == 8);
        e_sel = acc && (o == 8);

        check({tag, ".md_cal"},       32'(md_cal),       32'(e_cal));
        check({tag, ".other_reg_wr"}, 32'(other_reg_wr), 32'(e_wr));
        check({tag, ".op_a"},         op_a,              e_a);
        check({tag, ".op_b"},         op_b,              e_b);
        check({tag, ".op_signed"},    32'(op_signed),    32'(e_sgn));
        check({tag, ".rd_hilo_en"},   32'(rd_hilo_en),   32'(e_en));
        check({tag, ".rd_hilo_sel"},  32'(rd_hilo_sel),  32'(e_sel));
        check({tag, ".stall"},        32'(stall),        32'(exp_stall));
        check({tag, ".busy"},         32'(busy),         32'(exp_busy));

        if (busy)          busy_seen++;
        if (stall)         stall_seen++;
        if (md_cal != 0)   cal_pulses++;
        if (rd_hilo_en)    hilo_pulses++;
        if (other_reg_wr != 0) wr_pulses++;

        if (rst)
            rem = 0;
        else if (rem > 0)
            rem = rem - 1;
        else if (acc && is_arith)
            rem = (o == 3 || o == 4) ? 10 : 5;
    endtask

    task automatic clear_counts();
        busy_seen   = 0;
        stall_seen  = 0;
        cal_pulses  = 0;
        hilo_pulses = 0;
        wr_pulses   = 0;
    endtask

    task automatic idle_cycles(input string tag, input int n);
        for (int i = 0; i < n; i++)
            cyc(tag, 1'b0, 1'b0, 4'd0, 32'h0, 32'h0, 1'b0);
    endtask

    initial begin
        reset   = 1'b1;
        e_valid = 1'b0;
        md_op   = 4'd0;
        rs_val  = '0;
        rt_val  = '0;
        flush   = 1'b0;
        clear_counts();

        // Reset: outputs quiet, even with a valid op presented during reset.
        cyc("rst0", 1'b1, 1'b0, 4'd0, 32'h0, 32'h0, 1'b0);
        cyc("rst1", 1'b1, 1'b1, 4'd1, 32'h5, 32'h6, 1'b0);
        idle_cycles("post_rst", 2);

        // MULT rs=7 rt=-3: one issue pulse, then exactly 5 busy cycles.
        clear_counts();
        cyc("mult", 1'b0, 1'b1, 4'd1, 32'd7, 32'hFFFF_FFFD, 1'b0);
        idle_cycles("mult_wait", 7);
        check("mult.busy_cycles", 32'(busy_seen), 32'd5);
        check("mult.cal_pulses",  32'(cal_pulses), 32'd1);

        // DIVU then MFLO held at E: 10 stall cycles, readback on return.
        clear_counts();
        cyc("divu", 1'b0, 1'b1, 4'd4, 32'd100, 32'd7, 1'b0);
        for (int i = 0; i < 11; i++)
            cyc("mflo_held", 1'b0, 1'b1, 4'd8, 32'h0, 32'h0, 1'b0);
        check("divu.stall_cycles", 32'(stall_seen), 32'd10);
        check("divu.hilo_pulses",  32'(hilo_pulses), 32'd1);
        idle_cycles("divu_tail", 1);

        // MTHI while idle: one write pulse, never busy.
        clear_counts();
        cyc("mthi", 1'b0, 1'b1, 4'd5, 32'h1234, 32'hDEAD, 1'b0);
        idle_cycles("mthi_tail", 2);
        check("mthi.busy_cycles", 32'(busy_seen), 32'd0);
        check("mthi.wr_pulses",   32'(wr_pulses), 32'd1);

        // MULT with flush: nothing issued, never busy.
        clear_counts();
        cyc("mult_flush", 1'b0, 1'b1, 4'd1, 32'd7, 32'd3, 1'b1);
        idle_cycles("flush_tail", 2);
        check("flush.busy_cycles", 32'(busy_seen), 32'd0);
        check("flush.cal_pulses",  32'(cal_pulses), 32'd0);

        // Back-to-back: MULTU, then DIV waiting at E, accepted on return.
        clear_counts();
        cyc("multu", 1'b0, 1'b1, 4'd2, 32'hAAAA, 32'h5555, 1'b0);
        for (int i = 0; i < 6; i++)
            cyc("div_b2b", 1'b0, 1'b1, 4'd3, 32'h80, 32'h3, 1'b0);
        check("b2b.cal_pulses", 32'(cal_pulses), 32'd2);
        // Flush while in flight must not cancel: still busy to the end.
        clear_counts();
        cyc("inflight_flush", 1'b0, 1'b1, 4'd7, 32'h0, 32'h0, 1'b1);
        idle_cycles("b2b_tail", 11);
        check("b2b.busy_cycles", 32'(busy_seen), 32'd10);

        // Reset 3 cycles into a DIV: busy/stall/outputs clear next cycle.
        cyc("div_rst", 1'b0, 1'b1, 4'd3, 32'h99, 32'h3, 1'b0);
        idle_cycles("div_run", 2);
        cyc("div_rst_hit", 1'b1, 1'b1, 4'd7, 32'h0, 32'h0, 1'b0);
        cyc("after_rst", 1'b0, 1'b0, 4'd0, 32'h0, 32'h0, 1'b0);
        check("after_rst.busy", 32'(busy), 32'd0);

        // MADD: issue with 5 busy cycles when enabled, ignored otherwise.
        clear_counts();
        cyc("madd", 1'b0, 1'b1, 4'd9, 32'h11, 32'h22, 1'b0);
        for (int i = 0; i < 6; i++)
            cyc("madd_follow", 1'b0, 1'b1, 4'd10, 32'h1, 32'h2, 1'b1);
        check("madd.busy_cycles", 32'(busy_seen), MADD_EN ? 32'd5 : 32'd0);
        check("madd.stall_cycles", 32'(stall_seen), MADD_EN ? 32'd5 : 32'd0);
        idle_cycles("madd_tail", 6);

        // Opcodes 11-15 behave as NONE.
        for (int o = 11; o < 16; o++)
            cyc("op_hi", 1'b0, 1'b1, 4'(o), 32'h1, 32'h2, 1'b0);

        // Randomized run against the model.
        for (int i = 0; i < 600; i++) begin
            cyc("rand",
                ($urandom_range(0, 63) == 0),
                ($urandom_range(0, 3) != 0),
                4'($urandom_range(0, 15)),
                $urandom(), $urandom(),
                ($urandom_range(0, 7) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fails);
        $finish;
    end

endmodule
